// File: rtl/perceptron_pkg.sv
// -----------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron sequencer and its MAC/activation unit.
//   state_e     : sequencer FSM states (3-bit encoding)
//   DATA_W_DEF  : default width of weights, inputs and result
//   ACC_W_DEF   : default signed accumulator width
//   relu_sat()  : ReLU saturation ceiling (2^data_w - 1) for a given width
//   RELU_SAT    : saturation ceiling at the default data width
// -----------------------------------------------------------------------------
package perceptron_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 20;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_LOAD_X = 3'd2,
      ST_MAC    = 3'd3,
      ST_ACT    = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // Largest unsigned value representable in data_w bits.
   function automatic int relu_sat(input int data_w);
      return (1 << data_w) - 1;
   endfunction

   localparam int RELU_SAT = relu_sat(DATA_W_DEF);

endpackage

// File: rtl/perceptron_mac_unit.sv
// -----------------------------------------------------------------------------
// perceptron_mac_unit
// Purely combinational datapath for one perceptron term plus the activation.
//   w_i       : weight W[i], two's complement
//   x_i       : input X[i], unsigned
//   acc_i     : current accumulator value (signed)
//   acc_sum_o : acc_i + sign-extended (X[i] * W[i])
//   relu_o    : saturating ReLU of acc_i (0 .. 2^DATA_W-1)
// -----------------------------------------------------------------------------
module perceptron_mac_unit
   import perceptron_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              [DATA_W-1:0] w_i,
   input  logic              [DATA_W-1:0] x_i,
   input  logic signed       [ACC_W-1:0]  acc_i,
   output logic signed       [ACC_W-1:0]  acc_sum_o,
   output logic              [DATA_W-1:0] relu_o
);

   // Unsigned X (one extra sign bit) times signed W needs 2*DATA_W+1 bits.
   localparam int PROD_W  = 2 * DATA_W + 1;
   localparam int SAT_INT = relu_sat(DATA_W);
   localparam logic signed [ACC_W-1:0] SAT_ACC = ACC_W'(SAT_INT);

   logic signed [PROD_W-1:0] x_wide;
   logic signed [PROD_W-1:0] w_wide;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;

   always_comb begin
      // Zero-extend X so it is always non-negative, sign-extend W.
      x_wide    = PROD_W'($signed({1'b0, x_i}));
      w_wide    = PROD_W'($signed(w_i));
      prod      = x_wide * w_wide;
      prod_ext  = ACC_W'(prod);
      acc_sum_o = acc_i + prod_ext;
   end

   always_comb begin
      // NOTE: every path assigns relu_o, starting from a default, so no latch is inferred.
      relu_o = '0;
      if (acc_i[ACC_W-1] || (acc_i == '0)) begin
         relu_o = '0;
      end else if (acc_i > SAT_ACC) begin
         relu_o = DATA_W'(SAT_INT);
      end else begin
         relu_o = acc_i[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/perceptron_sequencer.sv
// -----------------------------------------------------------------------------
// perceptron_sequencer
// Loads a signed weight vector and an unsigned input vector byte-serially,
// runs one multiply-accumulate term per cycle, applies a saturating ReLU and
// presents the result with a valid/ready handshake.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   start     : command pulse, honoured only in IDLE
//   reuse_w   : with start, skip weight loading and keep the stored weights
//   in_data   : load byte (weights signed, inputs unsigned)
//   in_valid  : in_data valid
//   in_ready  : byte accepted when in_valid && in_ready (LOAD_W / LOAD_X)
//   out_data  : ReLU result, held until the next activation
//   out_valid : result available, held until out_ready
//   out_ready : consumer accepts the result
//   busy      : high in every state except IDLE
// -----------------------------------------------------------------------------
module perceptron_sequencer
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS = 2,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ACC_W    = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              reuse_w,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

   state_e                   state_q,     state_d;
   logic [IDX_W-1:0]         idx_q,       idx_d;
   logic signed [ACC_W-1:0]  acc_q,       acc_d;
   logic [DATA_W-1:0]        w_q [N_INPUTS];
   logic [DATA_W-1:0]        w_d [N_INPUTS];
   logic [DATA_W-1:0]        x_q [N_INPUTS];
   logic [DATA_W-1:0]        x_d [N_INPUTS];
   logic [DATA_W-1:0]        out_data_q,  out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     in_ready_q,  in_ready_d;
   logic                     busy_q,      busy_d;

   logic                     xfer;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [DATA_W-1:0]        relu;

   assign xfer = in_valid && in_ready_q;

   // The current index addresses both banks; the MAC unit only matters in MAC
   // and ACT, elsewhere its outputs are ignored.
   perceptron_mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .w_i       (w_q[idx_q]),
      .x_i       (x_q[idx_q]),
      .acc_i     (acc_q),
      .acc_sum_o (acc_sum),
      .relu_o    (relu)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      w_d         = w_q;
      x_d         = x_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = reuse_w ? ST_LOAD_X : ST_LOAD_W;
               idx_d   = '0;
            end
         end

         ST_LOAD_W: begin
            if (xfer) begin
               w_d[idx_q] = in_data;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_LOAD_X;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_LOAD_X: begin
            if (xfer) begin
               x_d[idx_q] = in_data;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  acc_d   = '0;
                  state_d = ST_MAC;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_MAC: begin
            acc_d = acc_sum;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = ST_ACT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         ST_ACT: begin
            out_data_d  = relu;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake/status outputs are registered from the next state so they
      // line up with the state register.
      in_ready_d = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_X);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         // NOTE: the banks are reset because a reuse_w command after reset must see all-zero weights.
         for (int i = 0; i < N_INPUTS; i++) begin
            w_q[i] <= '0;
            x_q[i] <= '0;
         end
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         w_q         <= w_d;
         x_q         <= x_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// -----------------------------------------------------------------------------
// tb_perceptron_sequencer
// Scoreboard bench: each command pushes the reference ReLU result into a
// queue; a negedge monitor pops and compares on every accepted output.
// -----------------------------------------------------------------------------
module tb_perceptron_sequencer;

   localparam int N      = 2;
   localparam int DW     = 8;
   localparam int AW     = 20;
   localparam int PERIOD = 10;

   typedef logic [N-1:0][DW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          reuse_w;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   int   n_checks = 0;
   int   n_passed = 0;
   int   exp_q[$];
   vec_t model_w;

   always #(PERIOD / 2) clk = ~clk;

   perceptron_sequencer #(
      .N_INPUTS (N),
      .DATA_W   (DW),
      .ACC_W    (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .reuse_w   (reuse_w),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Reference: signed dot product with plain integers, then clamp to 0..255.
   function automatic int model_relu(input vec_t w, input vec_t x);
      int acc = 0;
      for (int i = 0; i < N; i++) acc += int'($signed(w[i])) * int'(x[i]);
      if (acc <= 0) return 0;
      if (acc > 255) return 255;
      return acc;
   endfunction

   function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
      vec_t v;
      v[0] = a;
      v[1] = b;
      return v;
   endfunction

   // Monitor: an output is consumed at the next rising edge when both are high.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: output %0d with no expected result", out_data);
         end else begin
            check("sb_out_data", int'(out_data), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) tick();
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 64) begin
         tick();
         n++;
      end
      check("in_ready_for_byte", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic issue_start(input logic reuse);
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("idle_before_start", int'(busy), 0);
      start   = 1'b1;
      reuse_w = reuse;
      tick();
      start   = 1'b0;
      reuse_w = 1'b0;
      check("busy_after_start", int'(busy), 1);
      check("in_ready_after_start", int'(in_ready), 1);
   endtask

   // Runs one command up to the point where out_valid rises.
   task automatic run_cmd(input logic reuse, input vec_t w, input vec_t x, input int gap);
      int n;
      issue_start(reuse);
      if (!reuse) begin
         for (int i = 0; i < N; i++) send_byte(w[i], gap);
         model_w = w;
      end
      for (int i = 0; i < N; i++) send_byte(x[i], gap);
      exp_q.push_back(model_relu(model_w, x));
      n = 0;
      while (!out_valid && n < 32) begin
         tick();
         n++;
      end
      check("out_valid_latency", n, N + 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      out_ready = 1'b1;
      while (busy && n < 64) begin
         tick();
         n++;
      end
      check("return_to_idle", int'(busy), 0);
      check("out_valid_cleared", int'(out_valid), 0);
   endtask

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   stall_exp;
      vec_t rw;
      vec_t rx;
      logic rreuse;
      int   rgap;
      int   n;

      reset     = 1'b1;
      start     = 1'b0;
      reuse_w   = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      model_w   = '0;
      repeat (3) tick();

      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      reset = 1'b0;
      tick();

      // Basic full load: 4*2 + 9*3 = 35.
      run_cmd(1'b0, mk(8'd4, 8'd9), mk(8'd2, 8'd3), 0);
      wait_idle();
      check("out_data_held_after_accept", int'(out_data), model_relu(mk(8'd4, 8'd9), mk(8'd2, 8'd3)));

      // Reuse weights, gapped inputs, then backpressure with ignored starts.
      out_ready = 1'b0;
      run_cmd(1'b1, '0, mk(8'd1, 8'd1), 2);
      stall_exp = model_relu(model_w, mk(8'd1, 8'd1));
      for (int i = 0; i < 5; i++) begin
         if (i == 2) start = 1'b1;
         tick();
         start = 1'b0;
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_out_data", int'(out_data), stall_exp);
         check("stall_busy", int'(busy), 1);
         check("stall_in_ready", int'(in_ready), 0);
      end
      wait_idle();

      // Negative clamp: -5*10 + 1*3 = -47 -> 0.
      run_cmd(1'b0, mk(8'hFB, 8'd1), mk(8'd10, 8'd3), 0);
      wait_idle();

      // Saturation: 127*255*2 = 64770 -> 255.
      run_cmd(1'b0, mk(8'd127, 8'd127), mk(8'd255, 8'd255), 0);
      wait_idle();

      // Reset after the first X byte.
      issue_start(1'b1);
      send_byte(8'd5, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_w = '0;
      check("midrst_busy", int'(busy), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_data", int'(out_data), 0);
      run_cmd(1'b1, '0, mk(8'd7, 8'd7), 0);
      wait_idle();

      // start and reset together: reset wins.
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("start_rst_busy", int'(busy), 0);
      check("start_rst_in_ready", int'(in_ready), 0);
      tick();
      check("start_rst_still_idle", int'(busy), 0);

      // Randomized commands with random gaps and output backpressure.
      for (int k = 0; k < 25; k++) begin
         rreuse = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            rw[i] = DW'($urandom);
            rx[i] = DW'($urandom);
         end
         rgap = $urandom_range(0, 2);
         out_ready = ($urandom_range(0, 1) == 1);
         run_cmd(rreuse, rw, rx, rgap);
         n = 0;
         while (busy && n < 100) begin
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
            n++;
         end
         wait_idle();
      end

      repeat (4) tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/perceptron_sequencer.md
# perceptron_sequencer

Controller for the perceptron MAC datapath. It loads a signed weight vector and an unsigned input vector byte-serially over the 8-bit input bus, then runs one multiply-accumulate term per cycle. It applies a saturating ReLU and presents the 8-bit result with a valid/ready handshake. It sits between the top-level pin wrapper (which maps `ui_in`/`uo_out`/`uio_*` onto these ports) and the MAC/activation datapath, replacing hard-coded initial weights with runtime-loadable ones.

## Interface
- `N_INPUTS`, 2: vector length; legal range 1–8.
- `DATA_W`, 8: width of weights, inputs and result.
- `ACC_W`, 20: signed accumulator width; must be ≥ 2·DATA_W+1+clog2(N_INPUTS).

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `reuse_w` in 1: sampled with `start`. When 1, skip weight loading and reuse the stored weights.
- `in_data` in DATA_W: load byte (weights as two's complement, inputs unsigned).
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a byte. A transfer happens when `in_valid && in_ready`.
- `out_data` out DATA_W: ReLU result.
- `out_valid` out 1: result available; held until accepted.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE → LOAD_W on `start && !reuse_w`.
  - IDLE → LOAD_X on `start && reuse_w`.
  - LOAD_W → LOAD_X after N_INPUTS transfers.
  - LOAD_X → MAC after N_INPUTS transfers.
  - MAC → ACT after N_INPUTS cycles.
  - ACT → DONE after 1 cycle.
  - DONE → IDLE on `out_ready`.
- Load ordering: an index counter starts at 0 on entry to each load state and increments per transfer. Byte i goes to W[i] or X[i]. Gaps in `in_valid` simply stall the load.
- `in_ready` = 1 exactly in LOAD_W and LOAD_X.
- MAC: the accumulator is cleared on MAC entry. Each cycle adds the product of X[i], zero-extended to DATA_W+1 bits signed, and W[i], signed DATA_W bits. Each product is sign-extended to ACC_W.
- ACT: if acc ≤ 0, the result is 0. If acc > 2^DATA_W−1, the result is 2^DATA_W−1 (255). Otherwise it is acc[DATA_W-1:0]. The result is registered into `out_data` and `out_valid` is set.
- `out_data` keeps its last value after the result is accepted and until the next ACT.
- The weight bank persists across commands. Only `reset` or a new LOAD_W changes it.
- `start` outside IDLE is ignored; no queueing.
- Reset:
  - Returns the FSM to IDLE from any state, including mid-load.
  - Clears the counters, accumulator, W bank and X bank to 0.
  - Drives `out_data`=0, `out_valid`=0, `in_ready`=0 and `busy`=0.
  - If asserted in the same cycle as `start`, reset wins.
  - A `reuse_w` command issued after reset uses all-zero weights and produces 0.

## Timing
- `start` at edge t: `busy` and `in_ready` are 1 from t+1 onward.
- With continuous `in_valid`, LOAD_W takes N_INPUTS cycles and LOAD_X takes N_INPUTS cycles.
- The last X byte is accepted at edge k. MAC terms accumulate at edges k+1 through k+N_INPUTS. ACT registers the result at edge k+N_INPUTS+1, so `out_valid` is high N_INPUTS+1 cycles after the last input.
- `out_valid && out_ready` at edge d: `out_valid`=0 and the FSM is in IDLE from d+1. A `start` can be accepted at edge d+1.
- `out_valid` never drops without a handshake, except on `reset`.
- Minimum command period is 2N+N+3 cycles for a full load, or N+N+3 cycles with `reuse_w`.

## Structure
- Shared package `perceptron_pkg` holds:
  - the FSM state enum (IDLE, LOAD_W, LOAD_X, MAC, ACT, DONE; 3-bit encoding);
  - `DATA_W` and `ACC_W` defaults;
  - the ReLU saturation constant.
- One natural sub-module, `perceptron_mac_unit`: combinational product, sign extension and accumulate, plus ReLU/saturation, driven by the index and bank read ports.
- The FSM, counters, W/X register banks and handshake logic stay in `perceptron_sequencer`.

## Test plan
- Basic: full load W={4,9}, X={2,3} with `in_valid` held high → `out_data`=35 and `out_valid` exactly 3 cycles after the last X transfer.
- Negative clamp: W={0xFB(−5),1}, X={10,3} → acc=−47 → `out_data`=0.
- Saturation: W={127,127}, X={255,255} → acc=64770 → `out_data`=255.
- Reuse and backpressure:
  - After the basic case, `start` with `reuse_w`=1 and X={1,1} with `in_valid` gaps of 2 cycles → `out_data`=13.
  - Hold `out_ready`=0 for 5 cycles → `out_valid` and `out_data` stay stable. `start` pulses during DONE are ignored.
- Reset mid-operation: assert `reset` after the first X byte → next cycle in IDLE with all outputs 0. A following `start` with `reuse_w`=1 and X={7,7} → `out_data`=0.
- `start` and `reset` in the same cycle → remains IDLE with `busy`=0.
